// File: rtl/riscv_constants.sv
// Shared types for the memory arbiter slice.
//  arb_state_t : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//  arb_owner_t : which requester owns the transaction in flight
//  cnt_width() : bits needed to hold 0..max (at least 1)
package riscv_constants;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/riscv_arb_starve_cnt.sv
// Saturating starvation counter for the fetch side of the arbiter.
//  clk      in  clock
//  x_reset  in  synchronous active-low reset (count -> 0)
//  inc      in  fetch lost a tie-break this cycle
//  clr      in  fetch was served or is not asking; clear wins over inc
//  at_max   out count has reached MAX; never set when MAX == 0
module riscv_arb_starve_cnt
  import riscv_constants::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic x_reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned W = cnt_width(MAX);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                        cnt_d = '0;
    else if (inc && cnt_q != MAX_V) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!x_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // MAX == 0 disables the guard: the counter sits at 0 == MAX_V but must not force fetch.
  assign at_max = (MAX != 0) && (cnt_q == MAX_V);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-ported RAM between instruction fetch (i_*) and load/store (d_*).
// One transaction in flight: IDLE arbitrates and grants, ISSUE holds mem_req until
// mem_ready, WAIT routes the single mem_rvalid back to the owner.
//  clk, x_reset                   clock, synchronous active-low reset
//  i_req/i_addr/i_flush           fetch request, address, drop pending fetch response
//  i_gnt/i_rvalid/i_rdata         fetch grant, response valid, instruction
//  d_req/d_we/d_addr/d_wdata/d_be load/store request fields
//  d_gnt/d_rvalid/d_rdata         data grant, response valid (store ack), load data
//  mem_req/we/addr/wdata/be       memory request with latched fields
//  mem_ready/mem_rvalid/mem_rdata memory accept, response, read data
//  busy                           transaction in flight
module riscv_mem_arbiter
  import riscv_constants::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  x_reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_flush,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  logic                flush_q, flush_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] be_q, be_d;

  logic in_idle, pick_i, starve_max, starve_inc, starve_clr;

  assign in_idle = (state_q == ARB_IDLE);
  // Data wins ties unless fetch has lost STARVE_MAX rounds in a row.
  assign pick_i  = i_req & (~d_req | starve_max);

  assign starve_inc = in_idle & i_req & d_req & ~pick_i;
  assign starve_clr = in_idle & (~i_req | pick_i);

  riscv_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .x_reset (x_reset),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .at_max  (starve_max)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!x_reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_D;
      flush_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      flush_q <= flush_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Next state and field latch
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    flush_d = flush_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      ARB_IDLE: begin
        flush_d = 1'b0;
        if (i_req | d_req) begin
          state_d = ARB_ISSUE;
          if (pick_i) begin
            owner_d = OWN_I;
            we_d    = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
            be_d    = '0;
            // A redirect in the grant cycle already makes this fetch stale.
            flush_d = i_flush;
          end else begin
            owner_d = OWN_D;
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            be_d    = d_be;
          end
        end
      end
      ARB_ISSUE: begin
        if (owner_q == OWN_I && i_flush) flush_d = 1'b1;
        if (mem_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (owner_q == OWN_I && i_flush) flush_d = 1'b1;
        if (mem_rvalid) begin
          state_d = ARB_IDLE;
          flush_d = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs: everything is forced low while reset is asserted.
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    busy      = 1'b0;
    if (x_reset) begin
      i_gnt     = in_idle & pick_i;
      d_gnt     = in_idle & d_req & ~pick_i;
      mem_req   = (state_q == ARB_ISSUE);
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_be    = be_q;
      busy      = ~in_idle;
      if (state_q == ARB_WAIT && mem_rvalid) begin
        if (owner_q == OWN_I) begin
          // A flush arriving with the response also drops it.
          if (!(flush_q | i_flush)) begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
          end
        end else begin
          d_rvalid = 1'b1;
          d_rdata  = we_q ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule
